// File: rtl/cpu_sequencer_if.sv
// Single-ported memory bus shared by instruction fetch and load/store accesses.
// The sequencer drives the master side; the memory (or its model) is the slave.
interface cpu_sequencer_if;
    logic        mem_req;
    logic        mem_we_o;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we_o,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we_o,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: owns pc/ir/mdr and gates decoder write enables.
// Latency 4 cycles per ALU/branch instruction, 5 per load/store; stalls in FETCH/MEM until mem_ack.
module cpu_sequencer (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   step,
    input  logic                   halt,
    input  logic                   dec_pc_we,
    input  logic [5:0]             dec_pc_in,
    input  logic                   dec_reg_we,
    input  logic                   dec_mem_we,
    input  logic                   dec_sel2,
    input  logic [7:0]             daddr,
    cpu_sequencer_if.master        mem,
    output logic [15:0]            ir,
    output logic [15:0]            mdr,
    output logic [5:0]             pc,
    output logic                   reg_we_o,
    output logic                   busy,
    output logic [15:0]            instr_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    state_t      state_q;
    logic [5:0]  pc_q;
    logic [15:0] ir_q;
    logic [15:0] mdr_q;
    logic [15:0] cnt_q;
    logic        halt_q;
    logic        step_mode_q;
    logic        halt_d;

    // A halt arriving in the WB cycle itself must still stop at this boundary.
    assign halt_d = halt_q | halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= 6'd0;
            ir_q        <= 16'd0;
            mdr_q       <= 16'd0;
            cnt_q       <= 16'd0;
            halt_q      <= 1'b0;
            step_mode_q <= 1'b0;
        end else begin
            if (halt) halt_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (step) begin
                        state_q     <= FETCH;
                        step_mode_q <= 1'b1;
                        halt_q      <= 1'b0;
                    end else if (run) begin
                        state_q     <= FETCH;
                        step_mode_q <= 1'b0;
                        halt_q      <= 1'b0;
                    end
                end
                FETCH: begin
                    if (mem.mem_ack) begin
                        ir_q    <= mem.mem_rdata;
                        state_q <= DECODE;
                    end
                end
                DECODE: state_q <= EXEC;
                EXEC: state_q <= (dec_sel2 || dec_mem_we) ? MEM : WB;
                MEM: begin
                    if (mem.mem_ack) begin
                        if (dec_sel2) mdr_q <= mem.mem_rdata;
                        state_q <= WB;
                    end
                end
                WB: begin
                    pc_q    <= dec_pc_we ? dec_pc_in : pc_q + 6'd1;
                    cnt_q   <= cnt_q + 16'd1;
                    state_q <= (halt_d || step_mode_q || !run) ? IDLE : FETCH;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Bus outputs decode straight from state so an async reset clears them at once.
    always_comb begin
        mem.mem_addr = 8'd0;
        case (state_q)
            FETCH:   mem.mem_addr = {2'b00, pc_q};
            MEM:     mem.mem_addr = daddr;
            default: mem.mem_addr = 8'd0;
        endcase
    end

    assign mem.mem_req  = (state_q == FETCH) || (state_q == MEM);
    assign mem.mem_we_o = (state_q == MEM) && dec_mem_we;
    assign reg_we_o     = (state_q == WB) && dec_reg_we;
    assign busy         = (state_q != IDLE);
    assign pc           = pc_q;
    assign ir           = ir_q;
    assign mdr          = mdr_q;
    assign instr_count  = cnt_q;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 16-bit CPU. It owns the 6-bit program counter and instruction register and walks each instruction through fetch, decode, execute, memory and write-back. It shares the single-ported memory between instruction fetch and load/store data accesses, and gates the decoder's write enables so that each architectural write happens exactly once per instruction. It sits between the combinational instruction decoder, the register file/ALU datapath and the memory port.

## Interface
Parameters:
- none. Widths are fixed by the ISA: 16-bit instruction, 6-bit PC, 8-bit memory address, 16-bit memory data.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; while high in IDLE, start continuous execution
- step  in  1  pulse; in IDLE, execute exactly one instruction then return to IDLE
- halt  in  1  pulse; sticky request to stop at the next instruction boundary
- dec_pc_we  in  1  decoder branch-taken (already includes zf)
- dec_pc_in  in  6  decoder branch target
- dec_reg_we  in  1  decoder register-write request
- dec_mem_we  in  1  decoder store request
- dec_sel2  in  1  decoder load request
- daddr  in  8  data address from ALU result, valid in EXEC/MEM
- mem_rdata  in  16  memory read data, valid with mem_ack
- mem_ack  in  1  memory completes the current request
- mem_req  out  1  memory request
- mem_we_o  out  1  memory write strobe, store accesses only
- mem_addr  out  8  memory address
- ir  out  16  instruction register; feeds decoder op
- mdr  out  16  load data register; feeds register write mux
- pc  out  6  program counter
- reg_we_o  out  1  gated register-file write enable
- busy  out  1  high whenever state is not IDLE
- instr_count  out  16  retired-instruction counter

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- IDLE: step high -> FETCH with step_mode=1. Otherwise run high -> FETCH with step_mode=0. step has priority over run. The halt request is cleared on entry to FETCH from IDLE.
- FETCH: mem_req=1, mem_addr={2'b00,pc}, mem_we_o=0. On mem_ack, ir<=mem_rdata and go to DECODE. Otherwise stay.
- DECODE: one cycle for decoder outputs to settle -> EXEC.
- EXEC: dec_sel2 or dec_mem_we high -> MEM. Otherwise -> WB.
- MEM: mem_req=1, mem_addr=daddr, mem_we_o=dec_mem_we. On mem_ack:
  - if dec_sel2, mdr<=mem_rdata;
  - go to WB.
- WB: reg_we_o=dec_reg_we for this one cycle only.
  - PC update: if dec_pc_we, pc<=dec_pc_in; else pc<=pc+1, modulo 64 (63 -> 0).
  - instr_count<=instr_count+1, wrapping 65535 -> 0.
  - Next state: halt pending, step_mode=1 or run low -> IDLE. Otherwise -> FETCH.
- halt sampled high in any state sets a sticky halt request. It never aborts an in-flight memory request; it takes effect only at WB.
- reg_we_o and mem_we_o are 0 in every state except WB and MEM respectively. Decoder enables never reach the datapath ungated.
- Exactly one memory requester is active per cycle. mem_req is low in IDLE, DECODE, EXEC and WB.

## Timing
- Reset (rst_n low, asynchronous) values:
  - state=IDLE;
  - pc=0, ir=0, mdr=0, instr_count=0;
  - mem_req=0, mem_we_o=0, mem_addr=0;
  - reg_we_o=0, busy=0;
  - halt request=0, step_mode=0.
- Reset asserted mid-instruction drops mem_req and all write enables immediately, without waiting for a clock edge.
- Outputs are decoded from registered state. mem_ack may rise in the same cycle as mem_req; the FSM advances on the edge where mem_ack is sampled high.
- With mem_ack held high, a non-memory instruction takes 4 cycles (FETCH, DECODE, EXEC, WB). Load and store take 5 cycles.
- Each memory wait cycle adds one cycle in FETCH or MEM.
- pc, mdr and instr_count update on the WB-exit or MEM-exit edge. ir updates on the FETCH-exit edge.

## Test plan
- Reset, then run=1, mem_ack tied high, three non-memory instructions at addresses 0-2 -> reg_we_o pulses once every 4 cycles; pc reads 1, 2, 3; instr_count=3.
- Load with daddr=8'h20, mem_ack delayed 3 cycles, rdata 16'hBEEF:
  - mem_addr=8'h20 during MEM, mem_we_o=0;
  - mdr=16'hBEEF;
  - reg_we_o high for exactly one cycle in WB.
- Store at daddr=8'h10 -> mem_we_o high only while in MEM, reg_we_o stays 0, pc advances by 1.
- Branch at pc=63 with dec_pc_we=1, dec_pc_in=6'd5 -> pc=5. Same case with dec_pc_we=0 -> pc wraps to 0.
- step pulse in IDLE -> exactly one instruction retires and the FSM returns to IDLE. halt pulse during a stalled MEM -> the memory access completes and the FSM enters IDLE after WB.
- rst_n low during a stalled FETCH -> mem_req drops asynchronously; all outputs read reset values; busy=0.
